// File: rtl/mul_seq_ctrl_if.sv
// Operand/result handshake bundle for mul_seq_ctrl: the source drives the
// operands and the consumer drives out_ready (master); the multiplier is the slave.
interface mul_seq_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative radix-4 unsigned multiplier: two partial products per cycle folded into
// a carry-save accumulator by a 4:2 ha/fa compressor. Option: MUL_SEQ_EARLY_EXIT_EN.
module ha (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   assign s  = a ^ b;
   assign co = a & b;
endmodule

module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module mul_seq_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   mul_seq_ctrl_if.slave  bus,
   output logic           busy
);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = $clog2(WIDTH / 2);
   localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH / 2 - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t          state, state_nx;
   logic [WIDTH-1:0] a_r, b_r;
   logic [PW-1:0]   sum_r, carry_r, out_p_r;
   logic [SW-1:0]   step;
   logic            acc_done;

   logic [PW-1:0]   a_ext, pp0, pp1, cs_s;
   logic [PW-2:0]   s1, c1, cs_c;

   assign a_ext = {{WIDTH{1'b0}}, a_r};
   assign pp0   = (a_ext & {PW{b_r[0]}}) << {step, 1'b0};
   assign pp1   = (a_ext & {PW{b_r[1]}}) << {step, 1'b1};

   // Two fa rows per column; carries leaving the top column are dropped (mod 2^PW),
   // so the top column reduces to a plain parity of its five inputs.
   for (genvar i = 0; i < PW; i++) begin : g_col
      if (i == PW - 1) begin : g_top
         assign cs_s[i] = sum_r[i] ^ carry_r[i] ^ pp0[i] ^ pp1[i] ^ c1[i-1];
      end else begin : g_cell
         fa u_fa0 (.a(sum_r[i]), .b(carry_r[i]), .ci(pp0[i]), .s(s1[i]), .co(c1[i]));
         if (i == 0) begin : g_lsb
            ha u_ha1 (.a(s1[i]), .b(pp1[i]), .s(cs_s[i]), .co(cs_c[i]));
         end else begin : g_mid
            fa u_fa1 (.a(s1[i]), .b(pp1[i]), .ci(c1[i-1]), .s(cs_s[i]), .co(cs_c[i]));
         end
      end
   end

`ifdef MUL_SEQ_EARLY_EXIT_EN
   assign acc_done = (step == LAST_STEP) || (b_r[WIDTH-1:2] == '0);
`else
   assign acc_done = (step == LAST_STEP);
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = ACCUM;
         ACCUM:   if (acc_done) state_nx = RESOLVE;
         RESOLVE: state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (clr) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= '0;
         step    <= '0;
         out_p_r <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r     <= bus.in_a;
                  b_r     <= bus.in_b;
                  sum_r   <= '0;
                  carry_r <= '0;
                  step    <= '0;
               end
            end
            ACCUM: begin
               sum_r   <= cs_s;
               carry_r <= {cs_c, 1'b0};
               b_r     <= b_r >> 2;
               if (!acc_done) step <= step + SW'(1);
            end
            RESOLVE: out_p_r <= sum_r + carry_r;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_p     = out_p_r;
   assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (WIDTH=8): products and handshake timing are
// predicted from plain arithmetic; honours MUL_SEQ_EARLY_EXIT_EN for latency.
module tb_mul_seq_ctrl;
   localparam int W = 8;

   logic clk, rst_n, clr, busy;
   int   errors = 0;
   int   checks = 0;

   mul_seq_ctrl_if #(.WIDTH(W)) bus ();

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus.slave),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned p;
      p = int'(a) * int'(b);
      return p[2*W-1:0];
   endfunction

   // Samples (counting the accept edge as 0) until out_valid is seen high.
   function automatic int ref_lat(input logic [W-1:0] b);
      int n;
      n = W / 2;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      n = 0;
      for (int i = 0; i < W; i++) if (b[i]) n = i / 2 + 1;
      if (n < 1) n = 1;
`endif
      return n + 2;
   endfunction

   // Drive one operation; stall = cycles out_ready is held low once out_valid shows.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         output logic [2*W-1:0] p, output int lat, output int side_err);
      int n;
      side_err = 0;
      lat = -1;
      p = '0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_valid = 1'b1;
      bus.out_ready = (stall == 0);
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 60 && lat < 0; k++) begin
         if (bus.out_valid) lat = k;
         else begin
            if (!busy || bus.in_ready) side_err++;
            tick();
         end
      end
      if (lat > 0) begin
         p = bus.out_p;
         for (int s = 0; s < stall; s++) begin
            if (!bus.out_valid || bus.out_p !== p || bus.in_ready || !busy) side_err++;
            tick();
         end
         bus.out_ready = 1'b1;
         tick();
         if (bus.out_valid || !bus.in_ready || busy) side_err++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = 8'hA7;
      bus.in_b = 8'h3C;
      tick();
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.out_p !== 16'h0000) begin errors++; $display("FAIL reset_out_p got=%h exp=0000", bus.out_p); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [2*W-1:0] p;
      int lat, se;
      run_op(8'hFF, 8'hFF, 0, p, lat, se);
      checks++;
      if (p !== 16'hFE01) begin errors++; $display("FAIL basic_prod got=%h exp=fe01", p); end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL basic_latency got=%0d exp=6", lat); end
      checks++;
      if (se !== 0) begin errors++; $display("FAIL basic_busy_valid_window got=%0d exp=0", se); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   ta [2];
      logic [W-1:0]   tb [2];
      logic [2*W-1:0] res [2];
      int when [2];
      int acc_t [2];
      int idx, nres;
      logic acc;
      ta[0] = 8'h00; tb[0] = 8'hA5;
      ta[1] = 8'h80; tb[1] = 8'h02;
      idx = 0; nres = 0;
      res[0] = '1; res[1] = '1;
      when[0] = -100; when[1] = -100; acc_t[0] = -100; acc_t[1] = -100;
      bus.out_ready = 1'b1;
      bus.in_a = ta[0];
      bus.in_b = tb[0];
      bus.in_valid = 1'b1;
      for (int t = 0; t < 40 && nres < 2; t++) begin
         if (bus.out_valid) begin
            res[nres] = bus.out_p;
            when[nres] = t;
            nres++;
         end
         acc = bus.in_ready && bus.in_valid;
         if (acc) acc_t[idx] = t;
         tick();
         if (acc) begin
            idx++;
            if (idx < 2) begin
               bus.in_a = ta[idx];
               bus.in_b = tb[idx];
            end else bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (nres !== 2) begin errors++; $display("FAIL b2b_result_count got=%0d exp=2", nres); end
      checks++;
      if (res[0] !== ref_prod(ta[0], tb[0])) begin errors++; $display("FAIL b2b_prod0 got=%h exp=%h", res[0], ref_prod(ta[0], tb[0])); end
      checks++;
      if (res[1] !== ref_prod(ta[1], tb[1])) begin errors++; $display("FAIL b2b_prod1 got=%h exp=%h", res[1], ref_prod(ta[1], tb[1])); end
      checks++;
      if (when[0] - acc_t[0] !== ref_lat(tb[0])) begin errors++; $display("FAIL b2b_latency0 got=%0d exp=%0d", when[0] - acc_t[0], ref_lat(tb[0])); end
      checks++;
      if (acc_t[1] !== when[0] + 1) begin errors++; $display("FAIL b2b_second_accept got=%0d exp=%0d", acc_t[1], when[0] + 1); end
      checks++;
      if (when[1] - acc_t[1] !== ref_lat(tb[1])) begin errors++; $display("FAIL b2b_latency1 got=%0d exp=%0d", when[1] - acc_t[1], ref_lat(tb[1])); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] p;
      int lat, se;
      run_op(8'h12, 8'h34, 5, p, lat, se);
      checks++;
      if (p !== 16'h03A8) begin errors++; $display("FAIL bp_prod got=%h exp=03a8", p); end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL bp_latency got=%0d exp=6", lat); end
      checks++;
      if (se !== 0) begin errors++; $display("FAIL bp_hold_stable got=%0d exp=0", se); end
   endtask

   task automatic test_abort_reset();
      logic [2*W-1:0] p;
      int lat, se, stray;
      bus.out_ready = 1'b1;
      bus.in_a = 8'h55;
      bus.in_b = 8'h55;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({bus.out_valid, bus.out_p, busy, bus.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1})
         begin errors++; $display("FAIL abort_rst_outputs got=%b_%h_%b_%b exp=0_0000_0_1", bus.out_valid, bus.out_p, busy, bus.in_ready); end
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) stray++;
         tick();
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL abort_rst_no_result got=%0d exp=0", stray); end
      run_op(8'h03, 8'h07, 0, p, lat, se);
      checks++;
      if (p !== 16'h0015) begin errors++; $display("FAIL abort_rst_next_prod got=%h exp=0015", p); end
   endtask

   task automatic test_clr();
      logic [2*W-1:0] p;
      int lat, se, stray;
      bus.out_ready = 1'b1;
      bus.in_a = 8'h77;
      bus.in_b = 8'h99;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if ({busy, bus.in_ready, bus.out_valid} !== 3'b010)
         begin errors++; $display("FAIL clr_idle got=%b%b%b exp=010", busy, bus.in_ready, bus.out_valid); end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid || busy) stray++;
         tick();
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL clr_no_result got=%0d exp=0", stray); end
      run_op(8'hFF, 8'h01, 0, p, lat, se);
      checks++;
      if (p !== 16'h00FF) begin errors++; $display("FAIL clr_next_prod got=%h exp=00ff", p); end
      checks++;
      if (lat !== ref_lat(8'h01)) begin errors++; $display("FAIL clr_next_latency got=%0d exp=%0d", lat, ref_lat(8'h01)); end
   endtask

   task automatic test_early_exit();
      logic [W-1:0] vb [3];
      logic [2*W-1:0] p;
      int lat, se;
      vb[0] = 8'h01; vb[1] = 8'h40; vb[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         run_op(8'h12, vb[i], 0, p, lat, se);
         checks++;
         if (p !== ref_prod(8'h12, vb[i])) begin errors++; $display("FAIL ee_prod[%0d] got=%h exp=%h", i, p, ref_prod(8'h12, vb[i])); end
         checks++;
         if (lat !== ref_lat(vb[i])) begin errors++; $display("FAIL ee_latency[%0d] got=%0d exp=%0d", i, lat, ref_lat(vb[i])); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic [2*W-1:0] p;
      int lat, se;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 8);
         run_op(a, b, int'($urandom_range(0, 3)), p, lat, se);
         checks++;
         if (p !== ref_prod(a, b)) begin errors++; $display("FAIL rand_prod[%0d] %h*%h got=%h exp=%h", i, a, b, p, ref_prod(a, b)); end
         checks++;
         if (lat !== ref_lat(b)) begin errors++; $display("FAIL rand_latency[%0d] b=%h got=%0d exp=%0d", i, b, lat, ref_lat(b)); end
         checks++;
         if (se !== 0) begin errors++; $display("FAIL rand_handshake[%0d] got=%0d exp=0", i, se); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_abort_reset();
      test_clr();
      test_early_exit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative unsigned multiply sequencer with valid/ready handshakes on input and output.
- Per cycle, generates two partial products from the next 2 multiplier bits and folds them into a carry-save accumulator through a 4:2 compression built from the team's ha/fa cells.
- Resolves the final product with one carry-propagate add.
- Sits between the operand source and the result consumer; replaces a full parallel partial-product tree where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- clr  in  1  synchronous abort. Returns the block to IDLE and discards the operation in flight.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product present.
- out_ready  in  1  consumer takes the product.
- out_p  out  2*WIDTH  product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a rising edge) sets: state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, and all internal registers to 0.
- Reset or clr asserted mid-operation aborts it. No out_valid is produced for that operation. rst_n has priority over clr.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a_r=in_a, b_r=in_b; clear sum_r, carry_r (2*WIDTH each); step=0; go to ACCUM.
- ACCUM, each cycle:
  - pp0 = (a_r & {WIDTH{b_r[0]}}) << (2*step).
  - pp1 = (a_r & {WIDTH{b_r[1]}}) << (2*step+1).
  - {sum_r, carry_r} <= 4:2 compress(sum_r, carry_r, pp0, pp1), truncated mod 2^(2*WIDTH).
  - b_r <= b_r >> 2; step <= step+1.
  - After step WIDTH/2-1 is processed, go to RESOLVE.
- RESOLVE: out_p <= sum_r + carry_r (mod 2^(2*WIDTH)); out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1. out_p is held stable while out_ready=0.
  - On out_ready=1: out_valid <= 0 and go to IDLE.
  - in_ready stays 0 in DONE. The next operand can be accepted one cycle after the output handshake.
- in_ready=0 in ACCUM, RESOLVE and DONE. in_valid there is ignored, and operands must be held by the source.
- Latency: count the accepting edge as edge 0. out_valid rises at edge WIDTH/2+2, i.e. edge 6 for WIDTH=8.
- Throughput: one result per WIDTH/2+3 cycles with out_ready tied high.
- step counter is ceil(log2(WIDTH/2)) bits wide and never wraps within an operation.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined: at the end of any ACCUM cycle, if the shifted b_r (after the >>2) is 0, go directly to RESOLVE.
  - ACCUM always lasts at least 1 cycle, so in_b=0 or in_b=1 gives out_valid at edge 3.
  - out_p is identical to the non-early-exit result.
- Undefined: ACCUM always runs exactly WIDTH/2 cycles regardless of operand values.

Test Plan:
- WIDTH=8, in_a=0xFF, in_b=0xFF, out_ready=1 -> out_p=0xFE01, out_valid high for exactly 1 cycle at edge 6 (macro off). busy=1 from edge 1 to edge 6, and busy=0 from edge 7.
- in_a=0x00, in_b=0xA5, then in_a=0x80, in_b=0x02 back-to-back with in_valid held -> out_p=0x0000 then 0x0100. The second operand is accepted on the first edge in_ready=1 after the first output handshake.
- Backpressure: in_a=0x12, in_b=0x34, out_ready=0 for 5 cycles after out_valid, then 1 -> out_p=0x03A8 stable the whole time. in_ready=0 until the cycle after the handshake.
- Abort: accept 0x55*0x55, then assert rst_n=0 at edge 2 for 1 cycle, then send 0x03*0x07 -> no result for the first operation. The second gives out_p=0x0015, and all outputs are 0 during reset.
- clr=1 at edge 3 of an operation -> returns to IDLE at edge 4 with out_valid never asserted. A following 0xFF*0x01 gives out_p=0x00FF.
- MUL_SEQ_EARLY_EXIT_EN defined: 0x12*0x01 -> out_p=0x0012 at edge 3. 0x12*0x40 -> out_p=0x0480 at edge 6. 0x12*0x00 -> out_p=0 at edge 3.
